// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the paired LFSR stimulus generator.
// galois_step works on a 64-bit container so one function serves any LFSR width up to 64.
package lfsr_pkg;

    localparam logic [31:0] DEF_DATA_TAPS = 32'h0040_0006;
    localparam logic [9:0]  DEF_ADDR_TAPS = 10'h008;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } gen_state_e;

    // One Galois shift: feedback is the MSB, and bit 0 always receives it.
    function automatic logic [63:0] galois_step(
        input logic [63:0] s,
        input logic [63:0] taps,
        input int unsigned w
    );
        logic [63:0] mask;
        logic [63:0] nxt;
        logic        fb;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        fb   = |(s & (64'd1 << (w - 1)));
        nxt  = (s << 1) & mask;
        if (fb) begin
            nxt = nxt ^ ((taps | 64'd1) & mask);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Single Galois LFSR with a runtime seed load and an unrolled multi-step advance.
// A zero seed is replaced by SEED so the register can never reach the all-zero lock-up state.
module lfsr_galois
    import lfsr_pkg::*;
#(
    parameter int           W     = 32,
    parameter logic [W-1:0] TAPS  = W'(DEF_DATA_TAPS),
    parameter logic [W-1:0] SEED  = '1,
    parameter int           STEPS = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    output logic [W-1:0] state,
    output logic [W-1:0] state_adv,
    output logic         zero_sub
);

    localparam logic [63:0] TAPS64 = 64'(TAPS);

    if (W < 2 || W > 64) begin : g_bad_width
        $error("lfsr_galois: W must be in 2..64");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_galois: SEED must be non-zero");
    end
    if (STEPS < 1 || STEPS > W) begin : g_bad_steps
        $error("lfsr_galois: STEPS must be in 1..W");
    end

    logic [63:0] acc;

    always_comb begin
        acc = 64'(state);
        for (int i = 0; i < STEPS; i++) begin
            acc = galois_step(acc, TAPS64, W);
        end
        state_adv = W'(acc);
    end

    assign zero_sub = load && (load_val == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= SEED;
        end else if (load) begin
            state <= zero_sub ? SEED : load_val;
        end else if (step) begin
            state <= state_adv;
        end
    end

endmodule

// File: rtl/lfsr_stim_gen.sv
// Paired data/address LFSR stimulus source streaming {addr,data} words in bursts or free-running.
// out_* are registered copies of the LFSR states, refreshed on start and on every accept.
module lfsr_stim_gen
    import lfsr_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] DATA_TAPS = DATA_W'(DEF_DATA_TAPS),
    parameter logic [DATA_W-1:0] DATA_SEED = '1,
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] ADDR_TAPS = ADDR_W'(DEF_ADDR_TAPS),
    parameter logic [ADDR_W-1:0] ADDR_SEED = '1,
    parameter int                STEPS     = 1,
    parameter int                LEN_W     = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              seed_load,
    input  logic [DATA_W-1:0] data_seed,
    input  logic [ADDR_W-1:0] addr_seed,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              seed_err
);

    gen_state_e        state_q, state_d;
    logic [LEN_W-1:0]  count_q, len_q;
    logic              start_ok, load_seeds, accept, last_word;
    logic [DATA_W-1:0] data_state, data_adv;
    logic [ADDR_W-1:0] addr_state, addr_adv;
    logic              data_zero, addr_zero;

    // Seed load takes priority over start, and abort takes priority over accept.
    assign start_ok   = (state_q == IDLE) && start && !seed_load;
    assign load_seeds = (state_q == IDLE) && seed_load;
    assign accept     = (state_q == RUN) && out_ready && !abort;
    assign last_word  = (len_q != '0) && (count_q == len_q - LEN_W'(1));

    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

    lfsr_galois #(
        .W     (DATA_W),
        .TAPS  (DATA_TAPS),
        .SEED  (DATA_SEED),
        .STEPS (STEPS)
    ) u_data_lfsr (
        .clk       (clk),
        .rstn      (rstn),
        .load      (load_seeds),
        .load_val  (data_seed),
        .step      (accept),
        .state     (data_state),
        .state_adv (data_adv),
        .zero_sub  (data_zero)
    );

    lfsr_galois #(
        .W     (ADDR_W),
        .TAPS  (ADDR_TAPS),
        .SEED  (ADDR_SEED),
        .STEPS (STEPS)
    ) u_addr_lfsr (
        .clk       (clk),
        .rstn      (rstn),
        .load      (load_seeds),
        .load_val  (addr_seed),
        .step      (accept),
        .state     (addr_state),
        .state_adv (addr_adv),
        .zero_sub  (addr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && last_word) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output words track the LFSRs: current state at start, advanced state on accept.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q  <= '0;
            len_q    <= '0;
            out_data <= '0;
            out_addr <= '0;
            seed_err <= 1'b0;
        end else begin
            if (start_ok) begin
                count_q  <= '0;
                len_q    <= burst_len;
                out_data <= data_state;
                out_addr <= addr_state;
            end
            if (accept) begin
                count_q  <= count_q + LEN_W'(1);
                out_data <= data_adv;
                out_addr <= addr_adv;
            end
            if (data_zero || addr_zero) begin
                seed_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_stim_gen.sv
// Self-checking bench: two generators (1 and 4 steps per word) against a word-level reference model.
// Directed scenarios first, then randomized control traffic with occasional resets.
module tb_lfsr_stim_gen;

    localparam logic [63:0] DSEED = 64'hFFFF_FFFF;
    localparam logic [63:0] ASEED = 64'h3FF;
    localparam logic [63:0] DTAPS = 64'h0040_0006;
    localparam logic [63:0] ATAPS = 64'h008;

    logic        clk;
    logic        rstn;
    logic        seed_load;
    logic [31:0] data_seed;
    logic [9:0]  addr_seed;
    logic        start;
    logic        abort;
    logic [15:0] burst_len;
    logic        out_ready;

    logic        v1, b1, dn1, e1;
    logic [31:0] d1;
    logic [9:0]  a1;
    logic        v4, b4, dn4, e4;
    logic [31:0] d4;
    logic [9:0]  a4;

    int assert_count = 0;
    int fail_count   = 0;

    // Reference model state, per instance [0]=1 step, [1]=4 steps.
    int          m_steps [2] = '{1, 4};
    logic [63:0] m_lfsr_d[2];
    logic [63:0] m_lfsr_a[2];
    logic [63:0] m_out_d [2];
    logic [63:0] m_out_a [2];
    logic        m_valid, m_done, m_err;
    int          m_len, m_cnt;

    lfsr_stim_gen #(.STEPS(1)) dut (
        .clk(clk), .rstn(rstn), .seed_load(seed_load), .data_seed(data_seed),
        .addr_seed(addr_seed), .start(start), .abort(abort), .burst_len(burst_len),
        .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_addr(a1),
        .busy(b1), .done(dn1), .seed_err(e1)
    );

    lfsr_stim_gen #(.STEPS(4)) dut4 (
        .clk(clk), .rstn(rstn), .seed_load(seed_load), .data_seed(data_seed),
        .addr_seed(addr_seed), .start(start), .abort(abort), .burst_len(burst_len),
        .out_valid(v4), .out_ready(out_ready), .out_data(d4), .out_addr(a4),
        .busy(b4), .done(dn4), .seed_err(e4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] ref_shift(input logic [63:0] s, input logic [63:0] taps, input int w);
        logic [63:0] modulus;
        logic [63:0] doubled;
        modulus = 64'd1 << w;
        doubled = (s * 2) % modulus;
        if (s >= (modulus / 2)) begin
            return doubled ^ (taps | 64'd1);
        end
        return doubled;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic sl, input logic [31:0] ds,
                                input logic [9:0] aseed, input logic st, input logic ab,
                                input logic [15:0] bl, input logic rd);
        logic was_done;
        if (!r) begin
            m_valid = 1'b0;
            m_done  = 1'b0;
            m_err   = 1'b0;
            m_len   = 0;
            m_cnt   = 0;
            for (int i = 0; i < 2; i++) begin
                m_lfsr_d[i] = DSEED;
                m_lfsr_a[i] = ASEED;
                m_out_d[i]  = 64'd0;
                m_out_a[i]  = 64'd0;
            end
        end else begin
            was_done = m_done;
            m_done   = 1'b0;
            if (m_valid) begin
                if (ab) begin
                    m_valid = 1'b0;
                end else if (rd) begin
                    for (int i = 0; i < 2; i++) begin
                        for (int k = 0; k < m_steps[i]; k++) begin
                            m_lfsr_d[i] = ref_shift(m_lfsr_d[i], DTAPS, 32);
                            m_lfsr_a[i] = ref_shift(m_lfsr_a[i], ATAPS, 10);
                        end
                        m_out_d[i] = m_lfsr_d[i];
                        m_out_a[i] = m_lfsr_a[i];
                    end
                    m_cnt++;
                    if (m_len != 0 && m_cnt == m_len) begin
                        m_valid = 1'b0;
                        m_done  = 1'b1;
                    end
                end
            end else if (!was_done) begin
                if (sl) begin
                    if (ds == 32'd0 || aseed == 10'd0) m_err = 1'b1;
                    for (int i = 0; i < 2; i++) begin
                        m_lfsr_d[i] = (ds == 32'd0) ? DSEED : 64'(ds);
                        m_lfsr_a[i] = (aseed == 10'd0) ? ASEED : 64'(aseed);
                    end
                end else if (st) begin
                    m_valid = 1'b1;
                    m_len   = int'(bl);
                    m_cnt   = 0;
                    for (int i = 0; i < 2; i++) begin
                        m_out_d[i] = m_lfsr_d[i];
                        m_out_a[i] = m_lfsr_a[i];
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        checkOutput("s1_valid", 64'(v1), 64'(m_valid));
        checkOutput("s1_busy", 64'(b1), 64'(m_valid));
        checkOutput("s1_done", 64'(dn1), 64'(m_done));
        checkOutput("s1_seed_err", 64'(e1), 64'(m_err));
        checkOutput("s1_data", 64'(d1), m_out_d[0]);
        checkOutput("s1_addr", 64'(a1), m_out_a[0]);
        checkOutput("s4_valid", 64'(v4), 64'(m_valid));
        checkOutput("s4_done", 64'(dn4), 64'(m_done));
        checkOutput("s4_data", 64'(d4), m_out_d[1]);
        checkOutput("s4_addr", 64'(a4), m_out_a[1]);
    endtask

    // Drive one cycle of inputs away from the edge, then check just after the edge.
    task automatic applyStimulus(input logic r, input logic sl, input logic [31:0] ds,
                                 input logic [9:0] aseed, input logic st, input logic ab,
                                 input logic [15:0] bl, input logic rd);
        rstn      = r;
        seed_load = sl;
        data_seed = ds;
        addr_seed = aseed;
        start     = st;
        abort     = ab;
        burst_len = bl;
        out_ready = rd;
        @(posedge clk);
        #1;
        model_update(r, sl, ds, aseed, st, ab, bl, rd);
        check_all();
    endtask

    task automatic idle_cycle();
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    initial begin
        int          acc;
        int          early;
        logic        done_seen;
        logic [31:0] held_d;
        logic [9:0]  held_a;
        logic        rd;

        // Reset, then a single-word burst
        applyStimulus(1'b0, 1'b0, 32'd0, 10'd0, 1'b0, 1'b0, 16'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 10'd0, 1'b0, 1'b0, 16'd0, 1'b0);
        checkOutput("rst_valid", 64'(v1), 64'd0);
        checkOutput("rst_data", 64'(d1), 64'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b1, 1'b0, 16'd1, 1'b1);
        checkOutput("t1_valid", 64'(v1), 64'd1);
        checkOutput("t1_data", 64'(d1), 64'hFFFF_FFFF);
        checkOutput("t1_addr", 64'(a1), 64'h3FF);
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b0, 1'b0, 16'd0, 1'b1);
        checkOutput("t1_done", 64'(dn1), 64'd1);
        checkOutput("t1_next_data", 64'(d1), 64'hFFBF_FFF9);
        checkOutput("t1_next_addr", 64'(a1), 64'h3F7);
        idle_cycle();
        checkOutput("t1_done_clear", 64'(dn1), 64'd0);

        // Free-run: address period must be 1023
        applyStimulus(1'b0, 1'b0, 32'd0, 10'd0, 1'b0, 1'b0, 16'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b1, 1'b0, 16'd0, 1'b1);
        early = 0;
        for (int k = 1; k <= 1023; k++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b0, 1'b0, 16'd0, 1'b1);
            if (k < 1023 && a1 == 10'h3FF) early++;
        end
        checkOutput("t2_early_repeat", 64'(early), 64'd0);
        checkOutput("t2_addr_period", 64'(a1), 64'h3FF);
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b0, 1'b1, 16'd0, 1'b1);

        // Four-word burst with alternating ready
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b1, 1'b0, 16'd4, 1'b0);
        acc       = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            rd = (i % 2 == 0);
            if (v1 && rd) acc++;
            applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b0, 1'b0, 16'd0, rd);
            if (dn1) done_seen = 1'b1;
        end
        checkOutput("t3_accepts", 64'(acc), 64'd4);
        checkOutput("t3_done_seen", 64'(done_seen), 64'd1);
        idle_cycle();

        // Zero data seed is substituted and flagged
        applyStimulus(1'b1, 1'b1, 32'd0, 10'h155, 1'b0, 1'b0, 16'd0, 1'b0);
        checkOutput("t4_seed_err", 64'(e1), 64'd1);
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b1, 1'b0, 16'd2, 1'b0);
        checkOutput("t4_data", 64'(d1), 64'hFFFF_FFFF);
        checkOutput("t4_addr", 64'(a1), 64'h155);
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b0, 1'b0, 16'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b0, 1'b0, 16'd0, 1'b1);
        idle_cycle();

        // Abort on the third accept cycle, then resume from the held state
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b1, 1'b0, 16'd8, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b0, 1'b0, 16'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b0, 1'b0, 16'd0, 1'b1);
        held_d = d1;
        held_a = a1;
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b0, 1'b1, 16'd0, 1'b1);
        checkOutput("t5_valid", 64'(v1), 64'd0);
        checkOutput("t5_no_done", 64'(dn1), 64'd0);
        checkOutput("t5_held_data", 64'(d1), 64'(held_d));
        idle_cycle();
        checkOutput("t5_still_no_done", 64'(dn1), 64'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b1, 1'b0, 16'd1, 1'b0);
        checkOutput("t5_resume_data", 64'(d1), 64'(held_d));
        checkOutput("t5_resume_addr", 64'(a1), 64'(held_a));
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b0, 1'b0, 16'd0, 1'b1);
        idle_cycle();

        // Randomized control traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus(
                ($urandom_range(0, 99) != 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom()),
                ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023)),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 15) == 0),
                16'($urandom_range(0, 6)),
                1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a free-running burst
        idle_cycle();
        idle_cycle();
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b1, 1'b0, 16'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b0, 1'b0, 16'd0, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 10'd0, 1'b0, 1'b0, 16'd0, 1'b1);
        checkOutput("t6_rst_valid", 64'(v1), 64'd0);
        checkOutput("t6_rst_busy", 64'(b1), 64'd0);
        checkOutput("t6_rst_data", 64'(d1), 64'd0);
        checkOutput("t6_rst_addr", 64'(a1), 64'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 10'd0, 1'b1, 1'b0, 16'd1, 1'b0);
        checkOutput("t6_seed_data", 64'(d1), 64'hFFFF_FFFF);
        checkOutput("t6_seed_addr", 64'(a1), 64'h3FF);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
